// File: rtl/sine_pkg.sv
// Shared definitions for the sine generator / analyser pair: defaults, midscale and crossing-detector states.
package sine_pkg;

  localparam int unsigned SINE_SIZE_DEF  = 12;
  localparam int unsigned PHASE_SIZE_DEF = 10;
  localparam int unsigned HYST_DEF       = 16;
  localparam int unsigned PERIOD_W_DEF   = 16;
  localparam int unsigned MID            = 2 ** (SINE_SIZE_DEF - 1);

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } cross_state_e;

endpackage

// File: rtl/sine_wave_analyser_if.sv
// Sample stream in, per-cycle measurements out, for the sine wave analyser.
interface sine_wave_analyser_if #(
  parameter int unsigned SINE_SIZE = sine_pkg::SINE_SIZE_DEF,
  parameter int unsigned PERIOD_W  = sine_pkg::PERIOD_W_DEF
) ();
  logic [SINE_SIZE-1:0] sampleIn;
  logic                 sampleValid;
  logic                 clear;
  logic [PERIOD_W-1:0]  period;
  logic [PERIOD_W-1:0]  highTime;
  logic [SINE_SIZE-1:0] peak;
  logic [SINE_SIZE-1:0] trough;
  logic                 measValid;
  logic                 overflow;
  logic                 locked;

  modport master (
    output sampleIn, sampleValid, clear,
    input  period, highTime, peak, trough, measValid, overflow, locked
  );

  modport slave (
    input  sampleIn, sampleValid, clear,
    output period, highTime, peak, trough, measValid, overflow, locked
  );
endinterface

// File: rtl/sine_wave_analyser_crossing_detector.sv
// Hysteresis comparator around midscale plus the SEEK/LOW/HIGH tracker; flags rising crossings.
module crossing_detector
  import sine_pkg::*;
#(
  parameter int unsigned SINE_SIZE = sine_pkg::SINE_SIZE_DEF,
  parameter int unsigned HYST      = sine_pkg::HYST_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [SINE_SIZE-1:0] i_sample,
  input  logic                 i_valid,
  input  logic                 i_clear,
  input  logic                 i_abort,
  output logic                 o_rise_c,
  output logic                 o_in_high_c
);

  localparam int unsigned          MID_V = 2 ** (SINE_SIZE - 1);
  localparam logic [SINE_SIZE-1:0] LO_TH = SINE_SIZE'(MID_V - HYST);
  localparam logic [SINE_SIZE-1:0] HI_TH = SINE_SIZE'(MID_V + HYST);

  cross_state_e r_state;
  cross_state_e w_adv;
  cross_state_e w_next;
  logic         w_below;
  logic         w_above;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= SEEK;
    else        r_state <= w_next;
  end

  // w_adv is where the current sample would take us; clear/abort override it.
  always_comb begin
    w_adv       = r_state;
    w_next      = r_state;
    o_rise_c    = 1'b0;
    o_in_high_c = 1'b0;
    w_below     = (i_sample <= LO_TH);
    w_above     = (i_sample >= HI_TH);
    case (r_state)
      SEEK:    if (w_below) w_adv = LOW;
      LOW:     if (w_above) begin
                 w_adv    = HIGH;
                 o_rise_c = i_valid;
               end
      HIGH:    if (w_below) w_adv = LOW;
      default: w_adv = SEEK;
    endcase
    if (i_clear || i_abort) w_next = SEEK;
    else if (i_valid)       w_next = w_adv;
    o_in_high_c = i_valid && (w_adv == HIGH);
  end

endmodule

// File: rtl/sine_wave_analyser.sv
// Measures period, high time, peak and trough of each full cycle of an offset-binary sine stream.
module sine_wave_analyser
  import sine_pkg::*;
#(
  parameter int unsigned SINE_SIZE = sine_pkg::SINE_SIZE_DEF,
  parameter int unsigned HYST      = sine_pkg::HYST_DEF,
  parameter int unsigned PERIOD_W  = sine_pkg::PERIOD_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  sine_wave_analyser_if.slave  bus
);

  localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
  localparam logic [PERIOD_W-1:0] CNT_LAST = {{(PERIOD_W-1){1'b1}}, 1'b0};

  logic                 w_rise;
  logic                 w_in_high;
  logic                 w_sat;
  logic                 r_have_rx;
  logic [PERIOD_W-1:0]  r_cnt;
  logic [PERIOD_W-1:0]  r_hcnt;
  logic [SINE_SIZE-1:0] r_run_max;
  logic [SINE_SIZE-1:0] r_run_min;
  logic [PERIOD_W-1:0]  r_period;
  logic [PERIOD_W-1:0]  r_high_time;
  logic [SINE_SIZE-1:0] r_peak;
  logic [SINE_SIZE-1:0] r_trough;
  logic                 r_meas_valid;
  logic                 r_overflow;
  logic                 r_locked;

  // Period counter about to hit its ceiling: abandon this cycle and re-seek.
  assign w_sat = bus.sampleValid && r_have_rx && (r_cnt == CNT_LAST);

  crossing_detector #(
    .SINE_SIZE (SINE_SIZE),
    .HYST      (HYST)
  ) u_cross (
    .clock       (clock),
    .reset       (reset),
    .i_sample    (bus.sampleIn),
    .i_valid     (bus.sampleValid),
    .i_clear     (bus.clear),
    .i_abort     (w_sat),
    .o_rise_c    (w_rise),
    .o_in_high_c (w_in_high)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_have_rx    <= 1'b0;
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_run_max    <= '0;
      r_run_min    <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_peak       <= '0;
      r_trough     <= '0;
      r_meas_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_locked     <= 1'b0;
    end else if (bus.clear) begin
      r_have_rx    <= 1'b0;
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_run_max    <= '0;
      r_run_min    <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_peak       <= '0;
      r_trough     <= '0;
      r_meas_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (bus.sampleValid) begin
        if (w_sat) begin
          r_cnt      <= CNT_MAX;
          r_overflow <= 1'b1;
          r_have_rx  <= 1'b0;
        end else if (w_rise) begin
          if (r_have_rx) begin
            r_period     <= r_cnt + PERIOD_W'(1);
            r_high_time  <= r_hcnt;
            r_peak       <= r_run_max;
            r_trough     <= r_run_min;
            r_meas_valid <= 1'b1;
            r_locked     <= 1'b1;
          end
          // The crossing sample opens the new cycle and counts as high.
          r_have_rx <= 1'b1;
          r_cnt     <= '0;
          r_hcnt    <= PERIOD_W'(1);
          r_run_max <= bus.sampleIn;
          r_run_min <= bus.sampleIn;
        end else if (r_have_rx) begin
          r_cnt <= r_cnt + PERIOD_W'(1);
          if (w_in_high && (r_hcnt != CNT_MAX)) r_hcnt <= r_hcnt + PERIOD_W'(1);
          if (bus.sampleIn > r_run_max) r_run_max <= bus.sampleIn;
          if (bus.sampleIn < r_run_min) r_run_min <= bus.sampleIn;
        end
      end
    end
  end

  assign bus.period    = r_period;
  assign bus.highTime  = r_high_time;
  assign bus.peak      = r_peak;
  assign bus.trough    = r_trough;
  assign bus.measValid = r_meas_valid;
  assign bus.overflow  = r_overflow;
  assign bus.locked    = r_locked;

endmodule
